// File: rtl/wb_reg_file_pkg.sv
// -----------------------------------------------------------------------------
// wb_reg_file_pkg
// Shared CPU package for the register file and write-back path.
// Holds the default datapath/address widths and the hard-wired zero register
// address, plus a small helper used to test for that address.
// -----------------------------------------------------------------------------
package wb_reg_file_pkg;

    // Default widths for the integer register file.
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Register address that is hard-wired to zero.
    localparam int unsigned REG_ZERO = 0;

    // Width of the committed-write counter.
    localparam int unsigned WB_COUNT_W = 32;

    // True when the address refers to the hard-wired zero register.
    function automatic logic is_reg_zero(input logic [31:0] addr);
        return (addr == 32'(REG_ZERO));
    endfunction

endpackage : wb_reg_file_pkg

// File: rtl/wb_reg_file_mux.sv
// -----------------------------------------------------------------------------
// wb_mux
// 2:1 write-back source select, shared by the register file and the
// forwarding path so both see the same write-back value.
//
// Ports:
//   sel_i    1       source select: 1 = mem_i, 0 = alu_i
//   alu_i    DATA_W  ALU result
//   mem_i    DATA_W  memory load data
//   data_o   DATA_W  selected write-back value
// -----------------------------------------------------------------------------
module wb_mux #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              sel_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] mem_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = sel_i ? mem_i : alu_i;
    end

endmodule : wb_mux

// File: rtl/wb_reg_file.sv
// -----------------------------------------------------------------------------
// wb_reg_file
// Integer register file with write-back stage, write-through bypass and a
// committed-write counter.
//
// Ports:
//   clk_i       1       clock, all state updates on the rising edge
//   rst_i       1       asynchronous active-high reset
//   RegWrite_i  1       write-back enable from MEM/WB
//   MemtoReg_i  1       write-back source: 1 = Memout_i, 0 = ALUout_i
//   ALUout_i    DATA_W  ALU result from MEM/WB
//   Memout_i    DATA_W  memory load data from MEM/WB
//   rd_addr_i   ADDR_W  destination register address
//   rs1_addr_i  ADDR_W  decode-stage source address 1
//   rs2_addr_i  ADDR_W  decode-stage source address 2
//   rs1_data_o  DATA_W  source operand 1 (combinational, bypassed)
//   rs2_data_o  DATA_W  source operand 2 (combinational, bypassed)
//   wb_data_o   DATA_W  selected write-back value, for the forwarding unit
//   wb_count_o  32      number of committed register writes (wraps)
// -----------------------------------------------------------------------------
module wb_reg_file
    import wb_reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic [DATA_W-1:0]     ALUout_i,
    input  logic [DATA_W-1:0]     Memout_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    input  logic [ADDR_W-1:0]     rs1_addr_i,
    input  logic [ADDR_W-1:0]     rs2_addr_i,
    output logic [DATA_W-1:0]     rs1_data_o,
    output logic [DATA_W-1:0]     rs2_data_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic [WB_COUNT_W-1:0] wb_count_o
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic [WB_COUNT_W-1:0] wb_count_q;
    logic [WB_COUNT_W-1:0] wb_count_d;

    logic [DATA_W-1:0]     wb_data;
    logic                  rd_is_zero;
    logic                  commit;

    // -------------------------------------------------------------------------
    // Write-back source select
    // -------------------------------------------------------------------------
    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .sel_i  (MemtoReg_i),
        .alu_i  (ALUout_i),
        .mem_i  (Memout_i),
        .data_o (wb_data)
    );

    assign wb_data_o = wb_data;

    // -------------------------------------------------------------------------
    // Commit qualification
    // -------------------------------------------------------------------------
    always_comb begin
        rd_is_zero = is_reg_zero(32'(rd_addr_i));
        // rst_i gates commit so bypass is suppressed during reset as well.
        commit     = RegWrite_i && !rd_is_zero && !rst_i;
    end

    // -------------------------------------------------------------------------
    // Next-state for the array and the counter
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit) begin
            regs_d[rd_addr_i] = wb_data;
        end
        // x0 is never stored, whatever the write port does.
        regs_d[REG_ZERO] = '0;
    end

    always_comb begin
        wb_count_d = wb_count_q;
        if (commit) begin
            wb_count_d = wb_count_q + WB_COUNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // An edge that coincides with rst_i still high takes the reset branch, so
    // a write presented on the deasserting edge never commits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count_o = wb_count_q;

    // -------------------------------------------------------------------------
    // Read ports with write-through bypass
    // -------------------------------------------------------------------------
    always_comb begin
        if (rst_i || is_reg_zero(32'(rs1_addr_i))) begin
            rs1_data_o = '0;
        end else if (commit && (rs1_addr_i == rd_addr_i)) begin
            rs1_data_o = wb_data;
        end else begin
            rs1_data_o = regs_q[rs1_addr_i];
        end
    end

    always_comb begin
        if (rst_i || is_reg_zero(32'(rs2_addr_i))) begin
            rs2_data_o = '0;
        end else if (commit && (rs2_addr_i == rd_addr_i)) begin
            rs2_data_o = wb_data;
        end else begin
            rs2_data_o = regs_q[rs2_addr_i];
        end
    end

endmodule : wb_reg_file

// File: tb/tb_wb_reg_file.sv
module tb_wb_reg_file;

    logic        clk_i;
    logic        rst_i;
    logic        RegWrite_i;
    logic        MemtoReg_i;
    logic [31:0] ALUout_i;
    logic [31:0] Memout_i;
    logic [4:0]  rd_addr_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_count_o;

    int n_checks;
    int n_fail;

    wb_reg_file #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .RegWrite_i (RegWrite_i),
        .MemtoReg_i (MemtoReg_i),
        .ALUout_i   (ALUout_i),
        .Memout_i   (Memout_i),
        .rd_addr_i  (rd_addr_i),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rs1_data_o (rs1_data_o),
        .rs2_data_o (rs2_data_o),
        .wb_data_o  (wb_data_o),
        .wb_count_o (wb_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
        logic [31:0] exp_wb;
        logic [31:0] exp_cnt;   // counter after the edge
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wr, input logic m2r, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        RegWrite_i = wr;
        MemtoReg_i = m2r;
        ALUout_i   = alu;
        Memout_i   = mem;
        rd_addr_i  = rd;
        rs1_addr_i = rs1;
        rs2_addr_i = rs2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //           wr    m2r   alu           mem           rd  rs1 rs2  rs1_exp       rs2_exp       wb_exp        cnt
        vecs[0] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0,        5,  5,  0,  32'h1234_5678, 32'h0,        32'h1234_5678, 1};
        vecs[1] = '{1'b0, 1'b0, 32'h0,         32'h0,        0,  5,  5,  32'h1234_5678, 32'h1234_5678, 32'h0,        1};
        vecs[2] = '{1'b1, 1'b1, 32'h0,         32'hDEAD_BEEF, 0, 0,  0,  32'h0,        32'h0,        32'hDEAD_BEEF, 1};
        vecs[3] = '{1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0,        7,  7,  7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 2};
        vecs[4] = '{1'b0, 1'b0, 32'h1,         32'h0,        7,  7,  7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h1,        2};
        vecs[5] = '{1'b1, 1'b1, 32'h1,         32'hCAFE_F00D, 9, 5,  9,  32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, 3};
        vecs[6] = '{1'b0, 1'b1, 32'h0,         32'h0,        9,  9,  7,  32'hCAFE_F00D, 32'hA5A5_A5A5, 32'h0,        3};
        vecs[7] = '{1'b1, 1'b0, 32'h11,        32'h0,        7,  7,  9,  32'h11,        32'hCAFE_F00D, 32'h11,       4};
        vecs[8] = '{1'b0, 1'b0, 32'h0,         32'h0,        0,  7,  31, 32'h11,        32'h0,        32'h0,        4};
        vecs[9] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,        31, 31, 30, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 5};

        // Reset held, write with bypass candidate presented: reads must be 0.
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        drive(1'b1, 1'b0, 32'h99, 32'h0, 4, 4, 4);
        #1;
        chk("rst_bypass_rs1", rs1_data_o, 32'h0);
        chk("rst_bypass_rs2", rs2_data_o, 32'h0);
        chk("rst_wb_data", wb_data_o, 32'h99);

        // Write still presented on the edge where reset deasserts: no commit.
        @(posedge clk_i);
        rst_i <= 1'b0;
        #1;
        RegWrite_i = 1'b0;
        #1;
        chk("rst_deassert_x4", rs1_data_o, 32'h0);
        chk("rst_deassert_cnt", wb_count_o, 32'h0);

        // All addresses read 0 after reset.
        for (int i = 0; i < 32; i++) begin
            rs1_addr_i = 5'(i);
            rs2_addr_i = 5'(31 - i);
            #1;
            chk("reset_read_rs1", rs1_data_o, 32'h0);
            chk("reset_read_rs2", rs2_data_o, 32'h0);
        end
        chk("reset_count", wb_count_o, 32'h0);

        // Table-driven vectors: combinational checks before the edge, counter after.
        @(posedge clk_i);
        #1;
        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].wr, vecs[v].m2r, vecs[v].alu, vecs[v].mem,
                  vecs[v].rd, vecs[v].rs1, vecs[v].rs2);
            #1;
            chk($sformatf("vec%0d_rs1", v), rs1_data_o, vecs[v].exp_rs1);
            chk($sformatf("vec%0d_rs2", v), rs2_data_o, vecs[v].exp_rs2);
            chk($sformatf("vec%0d_wb", v), wb_data_o, vecs[v].exp_wb);
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d_cnt", v), wb_count_o, vecs[v].exp_cnt);
        end

        // Mid-cycle reset clears state immediately, then stays cleared.
        drive(1'b1, 1'b0, 32'h55, 32'h0, 3, 3, 7);
        @(posedge clk_i);
        #1;
        RegWrite_i = 1'b0;
        #1;
        chk("x3_written", rs1_data_o, 32'h55);
        chk("x3_cnt", wb_count_o, 32'h6);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("async_rst_x3", rs1_data_o, 32'h0);
        chk("async_rst_cnt", wb_count_o, 32'h0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_x3", rs1_data_o, 32'h0);
        chk("post_rst_x7", rs2_data_o, 32'h0);
        chk("post_rst_cnt", wb_count_o, 32'h0);

        // Counter wrap: preload the counter, then one committed write to x1.
        @(negedge clk_i);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        drive(1'b1, 1'b0, 32'h42, 32'h0, 1, 1, 0);
        @(posedge clk_i);
        #1;
        chk("wrap_cnt", wb_count_o, 32'h0);
        RegWrite_i = 1'b0;
        #1;
        chk("wrap_x1", rs1_data_o, 32'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wb_reg_file
